// File: rtl/regfile_param_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | regfile_param_pkg : shared operation codes and sweep state encodings      |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
package regfile_param_pkg;

  localparam logic [2:0] FS_DEC   = 3'b000;
  localparam logic [2:0] FS_INC   = 3'b001;
  localparam logic [2:0] FS_LOAD  = 3'b010;
  localparam logic [2:0] FS_CLR   = 3'b011;
  localparam logic [2:0] FS_LDL_Z = 3'b100;
  localparam logic [2:0] FS_LDL_K = 3'b101;
  localparam logic [2:0] FS_LDH   = 3'b110;
  localparam logic [2:0] FS_SEXT  = 3'b111;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } sweep_state_e;

  // Index width for n registers, never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_next_val.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | regfile_next_val : per-register function unit, (q, i, fun_sel) -> nxt    |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module regfile_next_val
  import regfile_param_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] i,
  input  logic [2:0]       fun_sel,
  output logic [WIDTH-1:0] nxt
);

  localparam int HALF = WIDTH / 2;

  always_comb begin
    nxt = q;
    case (fun_sel)
      FS_DEC:   nxt = q - WIDTH'(1);
      FS_INC:   nxt = q + WIDTH'(1);
      FS_LOAD:  nxt = i;
      FS_CLR:   nxt = '0;
      FS_LDL_Z: nxt = {{HALF{1'b0}}, i[HALF-1:0]};
      FS_LDL_K: nxt = {q[WIDTH-1:HALF], i[HALF-1:0]};
      FS_LDH:   nxt = {i[HALF-1:0], q[HALF-1:0]};
      FS_SEXT:  nxt = {{HALF{i[HALF-1]}}, i[HALF-1:0]};
      default:  nxt = q;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/regfile_param.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | regfile_param : GPR + scratch register file, two read ports, clear sweep  |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module regfile_param
  import regfile_param_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int NUM_GPR = 4,
  parameter int NUM_SCR = 4,
  parameter int BYPASS  = 1,
  parameter int OUT_REG = 0,
  localparam int NREG   = NUM_GPR + NUM_SCR,
  localparam int SELW   = sel_width(NREG)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   i,
  input  logic [2:0]         fun_sel,
  input  logic [NUM_GPR-1:0] reg_sel,
  input  logic [NUM_SCR-1:0] scr_sel,
  input  logic [SELW-1:0]    out_a_sel,
  input  logic [SELW-1:0]    out_b_sel,
  input  logic               clear_all,
  output logic [WIDTH-1:0]   out_a,
  output logic [WIDTH-1:0]   out_b,
  output logic               busy
);

  localparam logic [0:0] S_IDLE  = ST_IDLE;
  localparam logic [0:0] S_SWEEP = ST_SWEEP;

  logic [0:0]       r_state;
  logic [SELW-1:0]  r_idx;
  logic [NREG-1:0]  w_en;
  logic [WIDTH-1:0] w_rd [NREG];
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (clear_all) begin
            r_state <= S_SWEEP;
            r_idx   <= '0;
          end
        end
        S_SWEEP: begin
          if (r_idx == SELW'(NREG - 1)) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
          end else begin
            r_idx <= r_idx + SELW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_idx   <= '0;
        end
      endcase
    end
  end

  assign busy = (r_state == S_SWEEP);

  for (genvar k = 0; k < NREG; k++) begin : g_reg
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_nxt;
    logic             w_wr;
    logic             w_sweep_hit;

    // Select masks are active-low with the MSB addressing the first register.
    if (k < NUM_GPR) begin : g_gpr
      assign w_en[k] = ~reg_sel[NUM_GPR-1-k];
    end else begin : g_scr
      assign w_en[k] = ~scr_sel[NUM_SCR-1-(k-NUM_GPR)];
    end

    regfile_next_val #(.WIDTH(WIDTH)) u_fu (
      .q       (r_q),
      .i       (i),
      .fun_sel (fun_sel),
      .nxt     (w_nxt)
    );

    assign w_sweep_hit = (r_state == S_SWEEP) && (r_idx == SELW'(k));
    assign w_wr        = (r_state == S_IDLE) && w_en[k];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_q <= '0;
      end else if (w_sweep_hit) begin
        r_q <= '0;
      end else if (w_wr) begin
        r_q <= w_nxt;
      end
    end

    if (BYPASS != 0) begin : g_fwd
      assign w_rd[k] = w_sweep_hit ? '0 : (w_wr ? w_nxt : r_q);
    end else begin : g_nofwd
      assign w_rd[k] = r_q;
    end
  end

  // Out-of-range indices fall through to zero.
  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int k = 0; k < NREG; k++) begin
      if (out_a_sel == SELW'(k)) w_a = w_rd[k];
      if (out_b_sel == SELW'(k)) w_b = w_rd[k];
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [WIDTH-1:0] r_out_a;
    logic [WIDTH-1:0] r_out_b;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_out_a <= '0;
        r_out_b <= '0;
      end else begin
        r_out_a <= w_a;
        r_out_b <= w_b;
      end
    end
    assign out_a = r_out_a;
    assign out_b = r_out_b;
  end else begin : g_ocomb
    assign out_a = w_a;
    assign out_b = w_b;
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_param.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_regfile_param : directed self-checking bench for regfile_param         |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_regfile_param;

  localparam logic [2:0] FS_INC   = 3'b001;
  localparam logic [2:0] FS_LOAD  = 3'b010;
  localparam logic [2:0] FS_LDL_K = 3'b101;
  localparam logic [2:0] FS_LDH   = 3'b110;
  localparam logic [2:0] FS_SEXT  = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] i;
  logic [2:0]  fun_sel;
  logic [3:0]  reg_sel;
  logic [3:0]  scr_sel;
  logic [2:0]  out_a_sel;
  logic [2:0]  out_b_sel;
  logic        clear_all;

  logic [15:0] a0, b0, a1, b1, a2, b2;
  logic        busy0, busy1, busy2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Bypassing, combinational outputs, 4+4.
  regfile_param #(.WIDTH(16), .NUM_GPR(4), .NUM_SCR(4), .BYPASS(1), .OUT_REG(0)) u0 (
    .clk(clk), .rst_n(rst_n), .i(i), .fun_sel(fun_sel), .reg_sel(reg_sel),
    .scr_sel(scr_sel), .out_a_sel(out_a_sel), .out_b_sel(out_b_sel),
    .clear_all(clear_all), .out_a(a0), .out_b(b0), .busy(busy0)
  );

  // No bypass: reads show the current register contents.
  regfile_param #(.WIDTH(16), .NUM_GPR(4), .NUM_SCR(4), .BYPASS(0), .OUT_REG(0)) u1 (
    .clk(clk), .rst_n(rst_n), .i(i), .fun_sel(fun_sel), .reg_sel(reg_sel),
    .scr_sel(scr_sel), .out_a_sel(out_a_sel), .out_b_sel(out_b_sel),
    .clear_all(clear_all), .out_a(a1), .out_b(b1), .busy(busy1)
  );

  // Registered outputs, 3+3 so indices 6 and 7 are out of range.
  regfile_param #(.WIDTH(16), .NUM_GPR(3), .NUM_SCR(3), .BYPASS(1), .OUT_REG(1)) u2 (
    .clk(clk), .rst_n(rst_n), .i(i), .fun_sel(fun_sel), .reg_sel(reg_sel[3:1]),
    .scr_sel(scr_sel[3:1]), .out_a_sel(out_a_sel), .out_b_sel(out_b_sel),
    .clear_all(clear_all), .out_a(a2), .out_b(b2), .busy(busy2)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    i = '0; fun_sel = '0; reg_sel = 4'hF; scr_sel = 4'hF;
    out_a_sel = '0; out_b_sel = '0; clear_all = 1'b0;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("reset_a0", a0, 16'h0000);
    chk("reset_busy0", {15'b0, busy0}, 16'h0000);
    chk("reset_a2_reg", a2, 16'h0000);
    rst_n = 1'b1;

    // Load R1 then increment twice
    reg_sel = 4'b0111; fun_sel = FS_LOAD; i = 16'h1234;
    tick();
    fun_sel = FS_INC;
    tick();
    tick();
    reg_sel = 4'hF; out_a_sel = 3'd0;
    #1;
    chk("inc_r1_u0", a0, 16'h1236);
    chk("inc_r1_u1", a1, 16'h1236);

    // Increment wraps
    reg_sel = 4'b0111; fun_sel = FS_LOAD; i = 16'hFFFF;
    tick();
    fun_sel = FS_INC;
    tick();
    reg_sel = 4'hF;
    #1;
    chk("inc_wrap", a0, 16'h0000);

    // Forwarding of a load to R3 before the edge
    reg_sel = 4'b1101; fun_sel = FS_LOAD; i = 16'hABCD; out_b_sel = 3'd2;
    #1;
    chk("fwd_r3_bypass", b0, 16'hABCD);
    chk("fwd_r3_nobypass_old", b1, 16'h0000);
    tick();
    reg_sel = 4'hF;
    #1;
    chk("r3_after_edge_u1", b1, 16'hABCD);

    // Half-word operations on R2
    reg_sel = 4'b1011; fun_sel = FS_LOAD; i = 16'h1280; out_a_sel = 3'd1;
    tick();
    fun_sel = FS_SEXT; i = 16'h0080;
    #1;
    chk("sext_fwd", a0, 16'hFF80);
    tick();
    fun_sel = FS_LDL_K; i = 16'h0055;
    #1;
    chk("sext_q", a1, 16'hFF80);
    chk("ldlk_fwd", a0, 16'hFF55);
    tick();
    fun_sel = FS_LDH; i = 16'h0012;
    #1;
    chk("ldlk_q", a1, 16'hFF55);
    tick();
    reg_sel = 4'hF;
    #1;
    chk("ldh_u0", a0, 16'h1255);
    chk("ldh_u1", a1, 16'h1255);

    // Registered read latency; u0 index 4 = S1, u2 index 4 = S2
    scr_sel = 4'b0011; fun_sel = FS_LOAD; i = 16'h5A5A; out_a_sel = 3'd0; out_b_sel = 3'd2;
    tick();
    scr_sel = 4'hF;
    tick();
    chk("oreg_sel0", a2, 16'h0000);
    chk("oreg_r3", b2, 16'hABCD);
    out_a_sel = 3'd4;
    #1;
    chk("comb_sel4", a0, 16'h5A5A);
    chk("oreg_sel4_before", a2, 16'h0000);
    tick();
    chk("oreg_sel4_after", a2, 16'h5A5A);
    out_a_sel = 3'd6;
    tick();
    chk("oreg_idx6_zero", a2, 16'h0000);
    out_a_sel = 3'd5;
    tick();
    out_a_sel = 3'd7;
    tick();
    chk("oreg_idx7_zero", a2, 16'h0000);

    // Clear sweep over all 8 registers with writes attempted while busy
    reg_sel = 4'h0; scr_sel = 4'h0; fun_sel = FS_LOAD; i = 16'h7777;
    tick();
    reg_sel = 4'hF; scr_sel = 4'hF; clear_all = 1'b1;
    #1;
    chk("busy_not_yet", {15'b0, busy0}, 16'h0000);
    tick();
    clear_all = 1'b0; reg_sel = 4'h0; scr_sel = 4'h0; fun_sel = FS_LOAD; i = 16'h1111;
    for (int k = 0; k < 8; k++) begin
      out_a_sel = 3'(k); out_b_sel = 3'(k);
      clear_all = (k == 3);
      #1;
      chk($sformatf("sweep_busy_%0d", k), {15'b0, busy0}, 16'h0001);
      chk($sformatf("sweep_fwd_%0d", k), a0, 16'h0000);
      chk($sformatf("sweep_hold_%0d", k), a1, 16'h7777);
      tick();
      chk($sformatf("sweep_cleared_%0d", k), b1, 16'h0000);
    end
    clear_all = 1'b0;
    chk("sweep_done_busy", {15'b0, busy0}, 16'h0000);
    reg_sel = 4'hF; scr_sel = 4'hF;

    // Reset in the middle of a sweep aborts immediately
    reg_sel = 4'h0; scr_sel = 4'h0; fun_sel = FS_LOAD; i = 16'h4242;
    tick();
    reg_sel = 4'hF; scr_sel = 4'hF; clear_all = 1'b1;
    tick();
    clear_all = 1'b0;
    tick();
    out_a_sel = 3'd3;
    #1;
    chk("pre_reset_r4", a1, 16'h4242);
    chk("pre_reset_busy", {15'b0, busy0}, 16'h0001);
    rst_n = 1'b0;
    #1;
    chk("async_reset_a0", a0, 16'h0000);
    chk("async_reset_a1", a1, 16'h0000);
    chk("async_reset_busy", {15'b0, busy0}, 16'h0000);
    rst_n = 1'b1;
    tick();
    chk("post_reset_idle", {15'b0, busy0}, 16'h0000);
    chk("post_reset_r4", a1, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised successor to the 4+4 general/scratch register file.
- Configurable data width and register counts, per-register function unit (inc/dec/load/clear/half-word ops), two read ports with optional write-forwarding and optional output registers, and a multi-cycle clear-all sweep with a Busy flag.
- Sits between the ALU result bus and the ALU/address-register operand muxes in the datapath.

Parameters:
- WIDTH, 16, data width in bits; must be even and at least 4.
- NUM_GPR, 4, number of general-purpose registers, 1..8.
- NUM_SCR, 4, number of scratch registers, 1..8.
- BYPASS, 1, 1 = read ports forward the value being written this cycle.
- OUT_REG, 0, 1 = OutA/OutB registered (one-cycle read latency); 0 = combinational.
- Derived: NREG = NUM_GPR+NUM_SCR; SELW = clog2(NREG), minimum 1.

Ports:
- Clock, in, 1, rising-edge clock.
- Reset, in, 1, asynchronous active-low reset.
- I, in, WIDTH, write data.
- FunSel, in, 3, operation applied to every enabled register.
- RegSel, in, NUM_GPR, GPR enable mask, active-low; bit NUM_GPR-1 selects R1, LSB selects the last GPR.
- ScrSel, in, NUM_SCR, scratch enable mask, active-low; same bit ordering.
- OutASel, in, SELW, read index A.
- OutBSel, in, SELW, read index B.
- ClearAll, in, 1, single-cycle request to start the clear sweep.
- OutA, out, WIDTH, read data A.
- OutB, out, WIDTH, read data B.
- Busy, out, 1, high while the sweep runs.

Behaviour:
- Index map: 0..NUM_GPR-1 = R1..Rn; NUM_GPR..NREG-1 = S1..Sm.
- FunSel encoding (applied at the rising edge to each enabled register Q):
  - 000: Q-1.
  - 001: Q+1. Inc/dec wrap modulo 2^WIDTH, no flags.
  - 010: load I.
  - 011: clear to 0.
  - 100: {zeros, I[WIDTH/2-1:0]}.
  - 101: {Q upper half, I lower half}.
  - 110: {I lower half, Q lower half}.
  - 111: sign-extend I[WIDTH/2-1:0].
- Disabled registers hold. Any number of registers may be enabled at once.
- Read:
  - OutX = value of the selected register.
  - Index >= NREG returns 0.
  - OutASel == OutBSel is legal; both ports show the same value.
- BYPASS=1: if the selected register is enabled this cycle, OutX shows its computed next value combinationally. BYPASS=0: OutX shows the current Q.
- OUT_REG=1: the same value is captured at the edge and appears the cycle after the select is applied. OUT_REG=0: zero latency.
- Sweep FSM, states IDLE and SWEEP:
  - IDLE -> SWEEP when ClearAll=1; index counter loads 0; Busy rises on the next edge.
  - In SWEEP, each cycle clears register[idx] and increments idx.
  - At idx == NREG-1: that register is cleared and the FSM returns to IDLE. Total sweep = NREG cycles of Busy=1.
  - During SWEEP, RegSel/ScrSel/FunSel are ignored (no writes, no forwarding); reads remain valid. BYPASS forwards the sweep clear (0) for register[idx].
  - ClearAll during SWEEP is ignored.
  - ClearAll coincident with a write in IDLE: the write happens this edge and the sweep starts next cycle.
- Reset (Reset=0, asynchronous): all registers 0, FSM IDLE, idx 0, Busy 0, registered outputs 0. Reset mid-sweep aborts immediately; after release the FSM is IDLE.

Decomposition:
- Shared package:
  - FunSel encodings as named constants (FS_DEC, FS_INC, FS_LOAD, FS_CLR, FS_LDL_Z, FS_LDL_K, FS_LDH, FS_SEXT).
  - Sweep state enum (ST_IDLE, ST_SWEEP).
- Sub-module regfile_next_val: combinational function unit; (Q, I, FunSel) -> next Q, parametrised by WIDTH. Used once per register for both update and forwarding.
- The existing Register cell is not reused, because the forwarding path needs next-state visibility.

Test Plan:
1. Reset low mid-operation -> all outputs 0 and Busy=0 immediately, without a clock edge.
2. RegSel=0111 (R1 enabled), FunSel=010, I=0x1234, then FunSel=001 for 2 cycles; OutASel=0 -> R1=0x1236. Repeat from 0xFFFF with one increment -> wraps to 0x0000.
3. BYPASS=1, OUT_REG=0: load R3=0xABCD with OutBSel=2 in the same cycle -> OutB=0xABCD before the edge. BYPASS=0 -> OutB shows the old value until after the edge.
4. R2=0x1280, FunSel=111 with I=0x0080 -> R2=0xFF80; FunSel=101 with I=0x0055 -> R2=0xFF55; FunSel=110 with I=0x0012 -> R2=0x1255.
5. All 8 registers non-zero, pulse ClearAll -> Busy high for exactly 8 cycles. A write attempted during Busy is dropped. Each register reads 0 from the cycle after its sweep slot.
6. OUT_REG=1: change OutASel 0->4 -> OutA updates one cycle later. With NUM_GPR=3, NUM_SCR=3, index 6 or 7 -> 0.
